// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/exec/update controller that turns the C0 core into a free-running CPU.
// Defining SEQ_SINGLE_STEP_EN adds a step input that runs one instruction from IDLE.
module instr_sequencer #(
    parameter int ADDR_W = 8,
    parameter int INS_W = 21,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              restart,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic              step,
`endif
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [INS_W-1:0]  mem_data,
    output logic [INS_W-1:0]  ins,
    output logic              core_en,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);
    typedef enum logic [2:0] {IDLE, FETCH, EXEC, UPDATE, HALT} state_t;
    state_t state, next_state;
    logic [ADDR_W-1:0] pc_d, tgt_q, tgt_d;
    logic [INS_W-1:0] ins_d;
    logic take_q, take_d, single_q, single_d, step_go;
`ifdef SEQ_SINGLE_STEP_EN
    assign step_go = step;
`else
    assign step_go = 1'b0;
`endif
    assign mem_req = state == FETCH;
    assign core_en = state == EXEC;
    assign halted = state == HALT;
    assign mem_addr = pc;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc <= RESET_PC;
            ins <= '0;
            take_q <= 1'b0;
            tgt_q <= '0;
            single_q <= 1'b0;
        end else begin
            state <= next_state;
            pc <= pc_d;
            ins <= ins_d;
            take_q <= take_d;
            tgt_q <= tgt_d;
            single_q <= single_d;
        end
    end
    // Branch outcome is captured in EXEC so UPDATE sees a stable target.
    always_comb begin
        next_state = state;
        pc_d = pc;
        ins_d = ins;
        take_d = take_q;
        tgt_d = tgt_q;
        single_d = single_q;
        case (state)
            IDLE: if (run || step_go) begin
                next_state = FETCH;
                single_d = !run;
            end
            FETCH: if (mem_valid) begin
                next_state = EXEC;
                ins_d = mem_data;
            end
            EXEC: begin
                next_state = UPDATE;
                take_d = br_taken && ins[INS_W-1 -: 2] == 2'b00;
                tgt_d = br_addr;
            end
            UPDATE: if (take_q && tgt_q == pc) begin
                next_state = HALT;
            end else begin
                pc_d = take_q ? tgt_q : pc + 1'b1;
                next_state = run && !single_q ? FETCH : IDLE;
            end
            HALT: next_state = HALT;
            default: next_state = IDLE;
        endcase
        if (restart) begin
            next_state = IDLE;
            pc_d = RESET_PC;
            single_d = 1'b0;
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: randomized and directed checks of instr_sequencer against an instruction-level model.
module tb_instr_sequencer;
    logic clk = 0, rst_n = 0, run = 0, restart = 0, step = 0;
    logic mem_req, mem_valid = 0, core_en, br_taken = 0, halted;
    logic [7:0] mem_addr, br_addr = 0, pc;
    logic [20:0] mem_data = 0, ins;
    instr_sequencer dut (
        .clk(clk), .rst_n(rst_n), .run(run), .restart(restart),
`ifdef SEQ_SINGLE_STEP_EN
        .step(step),
`endif
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_data(mem_data),
        .ins(ins), .core_en(core_en), .br_taken(br_taken), .br_addr(br_addr), .pc(pc), .halted(halted)
    );
    always #5 clk = ~clk;
    localparam logic [20:0] MOV = 21'h0A0000, JMP = 21'h000000;
    logic [20:0] mem [256];
    logic br_tk [256];
    logic [7:0] br_ad [256];
    logic [7:0] exp_pc, pend_pc;
    logic [20:0] exp_ins;
    logic exp_core, exp_halted, pend_halt, run_upd, in_fetch, mem_hold, gap_chk;
    int compared = 0, mismatched = 0;
    int since_core, fetch_wait, fetch_lat, lat_min, lat_max, br_mode, n_exec, cyc, last_core;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        if (since_core == 1) run_upd = run;
        @(negedge clk);
        cyc++;
        if (since_core < 9) since_core++;
        if (since_core == 2) begin
            exp_pc = pend_pc;
            exp_halted = pend_halt;
        end
        chk("ins", ins, exp_ins);
        chk("core_en", core_en, exp_core);
        chk("halted", halted, exp_halted);
        if (in_fetch) chk("req_held", mem_req, 1);
        if (exp_core || exp_halted) chk("req_low", mem_req, 0);
        if (since_core == 2) chk("refetch", mem_req, run_upd && !exp_halted);
        if (mem_req) begin
            chk("mem_addr", mem_addr, exp_pc);
            chk("pc", pc, exp_pc);
        end
        br_taken = 1'($urandom_range(0, 1));
        br_addr = 8'($urandom);
        if (exp_core) begin
            n_exec++;
            since_core = 0;
            if (gap_chk) begin
                if (last_core >= 0) chk("core_gap", cyc - last_core, 3);
                last_core = cyc;
            end
            if (br_mode == 1) begin
                br_taken = br_tk[exp_pc];
                br_addr = br_ad[exp_pc];
            end else if (br_mode == 2) br_taken = 0;
            else if ($urandom_range(0, 7) == 0) br_addr = exp_pc;
            if (br_taken && exp_ins[20:19] == 2'b00) begin
                pend_halt = br_addr == exp_pc;
                pend_pc = br_addr;
            end else begin
                pend_halt = 0;
                pend_pc = exp_pc + 8'd1;
            end
        end
        exp_core = 0;
        mem_valid = 0;
        mem_data = 21'($urandom);
        if (mem_req) begin
            if (!in_fetch) begin
                in_fetch = 1;
                fetch_wait = 0;
                fetch_lat = $urandom_range(lat_min, lat_max);
            end
            if (!mem_hold && fetch_wait >= fetch_lat) begin
                mem_valid = 1;
                mem_data = mem[mem_addr];
                exp_ins = mem[mem_addr];
                exp_core = 1;
                in_fetch = 0;
            end
            fetch_wait++;
        end else mem_valid = ($urandom_range(0, 3) == 0);
    endtask
    task automatic do_reset();
        rst_n = 0; run = 0; restart = 0; step = 0; mem_valid = 0; br_taken = 0;
        #3;
        exp_pc = 0; exp_ins = 0; exp_core = 0; exp_halted = 0; pend_halt = 0; pend_pc = 0;
        in_fetch = 0; mem_hold = 0; gap_chk = 0; since_core = 9; n_exec = 0; last_core = -1;
        chk("rst_req", mem_req, 0);
        chk("rst_pc", pc, 0);
        chk("rst_ins", ins, 0);
        chk("rst_core_en", core_en, 0);
        chk("rst_halted", halted, 0);
        @(negedge clk);
        rst_n = 1;
    endtask
    task automatic do_restart();
        restart = 1;
        exp_pc = 0; exp_halted = 0; pend_halt = 0; in_fetch = 0; since_core = 9;
        tick();
        restart = 0;
    endtask
    task automatic run_until(input int n, input int budget);
        for (int i = 0; i < budget && n_exec < n; i++) tick();
        chk("exec_count", n_exec, n);
        tick();
        tick();
    endtask
    task automatic fill(input logic [20:0] w);
        for (int i = 0; i < 256; i++) begin
            mem[i] = w;
            br_tk[i] = 1;
            br_ad[i] = 8'($urandom);
        end
    endtask
    initial begin
        cyc = 0; lat_min = 0; lat_max = 0; br_mode = 1;
        fill(MOV);
        do_reset();
        gap_chk = 1;
        run = 1;
        run_until(3, 40);
        chk("pc_after3", pc, 3);
        gap_chk = 0;
        lat_min = 4; lat_max = 4;
        run_until(6, 60);
        chk("pc_lat4", pc, 6);
        lat_min = 0; lat_max = 0;
        do_reset();
        mem[0] = JMP; br_ad[0] = 8'h05;
        mem[5] = JMP; br_ad[5] = 8'h20;
        mem[8'h21] = JMP; br_ad[8'h21] = 8'hFF;
        br_tk[8'hFF] = 0;
        run = 1;
        run_until(3, 40);
        chk("jmp_then_mov_pc", pc, 8'h21);
        run_until(5, 40);
        chk("wrap_pc", pc, 8'h00);
        br_ad[0] = 8'h10;
        mem[8'h10] = JMP; br_ad[8'h10] = 8'h10;
        for (int i = 0; i < 40 && !exp_halted; i++) tick();
        chk("self_loop_halt", halted, 1);
        for (int i = 0; i < 10; i++) tick();
        chk("no_exec_in_halt", n_exec, 7);
        br_ad[0] = 8'h05;
        do_restart();
        chk("restart_pc", pc, 0);
        for (int i = 0; i < 5 && !mem_req; i++) tick();
        chk("resume_req", mem_req, 1);
        chk("resume_addr", mem_addr, 0);
        do_reset();
        fill(MOV);
        br_mode = 2;
        run = 1;
        for (int i = 0; i < 20 && n_exec < 1; i++) tick();
        mem_hold = 1;
        for (int i = 0; i < 10 && !mem_req; i++) tick();
        chk("hold_addr", mem_addr, 1);
        tick();
        run = 0;
        do_restart();
        mem_valid = 1;
        mem_data = 21'h1FFFFF;
        mem_hold = 0;
        tick();
        chk("late_valid_ins", ins, MOV);
        for (int i = 0; i < 5; i++) tick();
        chk("late_valid_exec", n_exec, 1);
        run = 1;
        for (int i = 0; i < 10 && !mem_req; i++) tick();
        #2 rst_n = 0;
        #1 chk("async_req", mem_req, 0);
        chk("async_pc", pc, 0);
        do_reset();
`ifdef SEQ_SINGLE_STEP_EN
        step = 1;
        tick();
        step = 0;
        for (int i = 0; i < 12; i++) tick();
        chk("step_exec", n_exec, 1);
        chk("step_pc", pc, 1);
        chk("step_idle_req", mem_req, 0);
`endif
        do_reset();
        for (int i = 0; i < 256; i++) begin
            mem[i] = 21'($urandom);
            if ($urandom_range(0, 2) == 0) mem[i][20:19] = 2'b00;
        end
        br_mode = 0; lat_min = 0; lat_max = 4;
        run = 1;
        for (int i = 0; i < 4000; i++) begin
            if (exp_halted && $urandom_range(0, 3) == 0) do_restart();
            else begin
                if ($urandom_range(0, 59) == 0) run = ~run;
                tick();
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
